// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bridge between the execute
// stage and a word-addressed data memory with byte-lane masks.
// A request is captured in IDLE, the memory strobe is held for
// WAIT_CYCLES+1 cycles in ACCESS, and the response waits in RESP until the
// core accepts it.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors (no strobe). Without it, such accesses are forced
// aligned and executed normally.
module load_store_unit #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [29:0] mem_address,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  // Last value of the ACCESS cycle counter before moving to RESP.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0]  state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [3:0]  mask_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wait_cnt_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        f3_legal;
  logic        is_half;
  logic        is_word;
  logic        skip_access;
  logic [31:0] eff_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_lanes;
  logic        accept;
  logic        access_last;

  logic [7:0]  lane_byte [4];
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  // Decode the incoming request: legality, effective address, lane mask and
  // lane-replicated store data.
  always_comb begin
    f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
               (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
               (req_funct3 == 3'b101);
    is_half  = (req_funct3[1:0] == 2'b01);
    is_word  = (req_funct3[1:0] == 2'b10);
    eff_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned  = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    skip_access = !f3_legal || misaligned;
`else
    // Misaligned halves/words silently drop the offending low address bits.
    skip_access = !f3_legal;
    if (is_half) begin
      eff_addr[0] = 1'b0;
    end else if (is_word) begin
      eff_addr[1:0] = 2'b00;
    end
`endif
    case (req_funct3[1:0])
      2'b00:   req_mask = 4'b0001 << eff_addr[1:0];
      2'b01:   req_mask = eff_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   req_mask = 4'b1111;
      default: req_mask = 4'b0000;
    endcase
    case (req_funct3[1:0])
      2'b00:   req_lanes = {4{req_wdata[7:0]}};
      2'b01:   req_lanes = {2{req_wdata[15:0]}};
      default: req_lanes = req_wdata;
    endcase
  end

  assign accept      = (state_reg == ST_IDLE) && req_valid;
  assign access_last = (state_reg == ST_ACCESS) && (wait_cnt_reg == WAIT_LAST);

  // Split the memory word into byte lanes for load extraction.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Select the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    load_byte = lane_byte[addr_reg[1:0]];
    load_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state logic for IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = skip_access ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (access_last) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the request fields; they stay stable through ACCESS and RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= 32'h0000_0000;
      mask_reg   <= 4'b0000;
      wdata_reg  <= 32'h0000_0000;
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= eff_addr;
      mask_reg   <= skip_access ? 4'b0000 : req_mask;
      wdata_reg  <= skip_access ? 32'h0000_0000 : req_lanes;
    end
  end

  // Count ACCESS cycles; zero whenever outside ACCESS so each entry starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= 4'd0;
    end else if ((state_reg == ST_ACCESS) && !access_last) begin
      wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end else begin
      wait_cnt_reg <= 4'd0;
    end
  end

  // Response data/error: loaded on entry to RESP, returned to idle value on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= RESET_RDATA;
      err_reg   <= 1'b0;
    end else if (accept && skip_access) begin
      rdata_reg <= 32'h0000_0000;
      err_reg   <= 1'b1;
    end else if (access_last) begin
      rdata_reg <= we_reg ? 32'h0000_0000 : load_ext;
      err_reg   <= 1'b0;
    end else if ((state_reg == ST_RESP) && rsp_ready) begin
      rdata_reg <= RESET_RDATA;
      err_reg   <= 1'b0;
    end
  end

  assign req_ready   = (state_reg == ST_IDLE);
  assign rsp_valid   = (state_reg == ST_RESP);
  assign rsp_rdata   = rdata_reg;
  assign rsp_err     = err_reg;
  assign mem_read    = (state_reg == ST_ACCESS) && !we_reg;
  assign mem_write   = (state_reg == ST_ACCESS) && we_reg;
  assign mem_address = addr_reg[31:2];
  assign mem_mask    = mask_reg;
  assign mem_wdata   = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit (WAIT_CYCLES=3).
// The reference model works on byte addresses, access sizes and a word
// array; the monitor compares strobes and responses as the DUT presents them.
module tb_load_store_unit;

  localparam int          WAIT      = 3;
  localparam logic [31:0] RST_RDATA = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [29:0] mem_address;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(
    .WAIT_CYCLES(WAIT),
    .RESET_RDATA(RST_RDATA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_mask   (mem_mask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        access;
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_issued = 0;
  logic [31:0] ref_mem [256];
  logic        force_low = 1'b0;
  int          last_rsp_cycles = 0;

  // Memory model: backdoor preload, combinational read, store commits on
  // the final strobe cycle only.
  logic [31:0] mem_arr [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h00;
  logic [31:0] bd_val = 32'h0;
  int          wr_run = 0;
  assign mem_rdata = mem_arr[mem_address[7:0]];

  always @(posedge clk) begin
    if (bd_we) begin
      mem_arr[bd_idx] <= bd_val;
    end else if (mem_write) begin
      if (wr_run == WAIT) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_mask[b]) mem_arr[mem_address[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      wr_run <= wr_run + 1;
    end else begin
      wr_run <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-address arithmetic on the word array.
  task automatic ref_issue(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    exp_t            e;
    int              size;
    int              sh;
    bit              legal;
    bit              mis;
    logic [31:0]     ea;
    logic [31:0]     word;
    longint unsigned lim;
    longint unsigned v;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = 1 << f3[1:0];
    mis   = legal && ((addr % size) != 0);
    ea    = legal ? addr - (addr % size) : addr;
    e.id = n_issued; e.we = we; e.f3 = f3; e.addr = addr;
    e.err = !legal; e.access = legal; e.rdata = 32'h0;
    e.waddr = 30'h0; e.mask = 4'h0; e.wdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.err = 1'b1;
      e.access = 1'b0;
    end
`else
    if (mis) e.err = 1'b0;
`endif
    if (e.access) begin
      sh      = ea % 4;
      e.waddr = 30'(ea / 4);
      e.mask  = 4'(((1 << size) - 1) << sh);
      lim     = (64'd1 << (8 * size)) - 1;
      e.wdata = (size == 4) ? wd : 32'((64'(wd) & lim) * ((size == 1) ? 64'h01010101 : 64'h00010001));
      word    = ref_mem[e.waddr[7:0]];
      if (we) begin
        for (int b = 0; b < 4; b++) if (e.mask[b]) word[8*b +: 8] = e.wdata[8*b +: 8];
        ref_mem[e.waddr[7:0]] = word;
      end else begin
        v = (64'(word) >> (8 * sh)) & lim;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~lim;
        e.rdata = 32'(v);
      end
    end
    sb_q.push_back(e);
    n_issued++;
  endtask

  // Present a request in IDLE; the following edge accepts it.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    ref_issue(we, f3, addr, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  // Randomized response backpressure, overridable by force_low.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks strobes against the queue head and pops on response handshake.
  initial begin
    exp_t        e;
    int          strobe_cnt = 0;
    int          rsp_cnt = 0;
    logic [31:0] hold_rdata = 32'h0;
    logic        hold_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        strobe_cnt = 0;
        rsp_cnt = 0;
      end else begin
        if (mem_read || mem_write) begin
          strobe_cnt++;
          if (sb_q.size() == 0) begin
            chk("strobe_unexpected", {30'h0, mem_read, mem_write}, 32'h0);
          end else begin
            e = sb_q[0];
            chk("strobe_allowed", {31'h0, e.access}, 32'h1);
            chk("strobe_dir", {30'h0, mem_read, mem_write}, e.we ? 32'h1 : 32'h2);
            chk("mem_address", {2'b00, mem_address}, {2'b00, e.waddr});
            chk("mem_mask", {28'h0, mem_mask}, {28'h0, e.mask});
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
          end
        end
        if (rsp_valid) begin
          if (rsp_cnt == 0) begin
            hold_rdata = rsp_rdata;
            hold_err = rsp_err;
          end else begin
            chk("rsp_rdata_stable", rsp_rdata, hold_rdata);
            chk("rsp_err_stable", {31'h0, rsp_err}, {31'h0, hold_err});
          end
          rsp_cnt++;
          chk("req_ready_resp", {31'h0, req_ready}, 32'h0);
          if (rsp_ready) begin
            if (sb_q.size() == 0) begin
              chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
            end else begin
              e = sb_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
              chk("strobe_cycles", strobe_cnt, e.access ? WAIT + 1 : 0);
              $display("txn %0d we=%0d f3=%0d addr=%h rdata=%h err=%0d strobes=%0d rsp_cycles=%0d",
                       e.id, e.we, e.f3, e.addr, rsp_rdata, rsp_err, strobe_cnt, rsp_cnt);
            end
            last_rsp_cycles = rsp_cnt;
            strobe_cnt = 0;
            rsp_cnt = 0;
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, RST_RDATA);
    chk({tag, "_strobes"}, {30'h0, mem_read, mem_write}, 32'h0);
    chk({tag, "_mem_address"}, {2'b00, mem_address}, 32'h0);
    chk({tag, "_mem_mask"}, {28'h0, mem_mask}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3_pool [8];
    logic [31:0] saved;
    int          guard;
    int          mem_bad;
    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state, then preload memory through the backdoor.
    #12 chk_reset_outputs("reset");
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 8'(i); bd_val = $urandom;
      ref_mem[i] = bd_val;
    end
    @(negedge clk);
    bd_we = 1'b0;
    rst = 1'b1;

    // Directed vectors.
    issue(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5);   // SB
    issue(1'b1, 3'd2, 32'h0000_0200, 32'h80FF_7F01);   // SW preload
    issue(1'b1, 3'd2, 32'h0000_0010, 32'h8001_1234);   // SW preload
    issue(1'b0, 3'd0, 32'h0000_0202, 32'h0);           // LB
    issue(1'b0, 3'd4, 32'h0000_0202, 32'h0);           // LBU
    issue(1'b0, 3'd1, 32'h0000_0012, 32'h0);           // LH
    issue(1'b0, 3'd5, 32'h0000_0012, 32'h0);           // LHU
    issue(1'b0, 3'd2, 32'h0000_0006, 32'h0);           // misaligned LW
    issue(1'b0, 3'd3, 32'h0000_0040, 32'h0);           // illegal funct3
    issue(1'b1, 3'd7, 32'h0000_0044, 32'hFFFF_FFFF);   // illegal store
    drain();

    // Wait states with held backpressure.
    force_low = 1'b1;
    issue(1'b0, 3'd2, 32'h0000_0008, 32'h0);
    repeat (WAIT + 7) @(negedge clk);
    force_low = 1'b0;
    drain();
    chk("backpressure_rsp_cycles", {31'h0, last_rsp_cycles >= 5}, 32'h1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      issue(1'($urandom_range(0, 1)), f3_pool[$urandom_range(0, 7)],
            32'($urandom_range(0, 1023)), $urandom);
    end
    drain();

    // Reset during the ACCESS phase of a store.
    saved = ref_mem[8'hC0];
    issue(1'b1, 3'd2, 32'h0000_0300, ~saved);
    guard = 0;
    while (!mem_write && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_store_started", {31'h0, mem_write}, 32'h1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("abort");
    sb_q.delete();
    ref_mem[8'hC0] = saved;
    repeat (3) @(negedge clk);
    chk("abort_mem_unchanged", mem_arr[8'hC0], saved);
    rst = 1'b1;

    // Post-abort sanity and full memory comparison.
    issue(1'b0, 3'd2, 32'h0000_0300, 32'h0);
    drain();
    mem_bad = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) mem_bad++;
    chk("memory_image", mem_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
